// File: rtl/alarm_scheduler.sv
// alarm_scheduler: confirm-qualified sensor requests share one buzzer through a round-robin grant.
// Define ALARM_FIXED_PRIO_EN to grant the lowest-index pending channel instead of round-robin.
module alarm_scheduler #(
    parameter int NUM_CH    = 3,
    parameter int CONFIRM   = 7,
    parameter int ALARM_LEN = 31,
    parameter int GAP_LEN   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [NUM_CH-1:0] i_sensor_in,
    input  logic              i_clear_all,
    output logic [NUM_CH-1:0] o_buzzer_out,
    output logic              o_busy,
    output logic [NUM_CH-1:0] o_pending,
    output logic [1:0]        o_active_id
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SOUND = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [3:0]        r_cnt [NUM_CH];
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] r_buzzer;
    logic              r_busy;
    logic [1:0]        r_active_id;
    logic [1:0]        r_ptr;
    logic [1:0]        r_state;
    logic [7:0]        r_dur;

    logic [NUM_CH-1:0] w_cfm_set;
    logic [NUM_CH-1:0] w_grant_oh;
    logic [NUM_CH-1:0] w_grant_clr;
    logic [NUM_CH-1:0] w_buzzer_nxt;
    logic [NUM_CH-1:0] w_pending_nxt;
    logic [1:0]        w_grant;
    logic [1:0]        w_state_nxt;
    logic [1:0]        w_active_id_nxt;
    logic [1:0]        w_ptr_nxt;
    logic [7:0]        w_dur_nxt;

`ifdef ALARM_FIXED_PRIO_EN
    function automatic logic [1:0] prio_pick(input logic [NUM_CH-1:0] req);
        logic [1:0] pick;
        pick = 2'd0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[k]) begin
                pick = 2'(k);
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [1:0] next_ptr(input logic [1:0] grant);
        return 2'd0;
    endfunction
`else
    // Descending scan so the smallest offset from the pointer wins.
    function automatic logic [1:0] rr_pick(input logic [NUM_CH-1:0] req, input logic [1:0] ptr);
        logic [2:0] idx;
        logic [1:0] pick;
        pick = 2'd0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + 3'(k);
            if (idx >= 3'(NUM_CH)) begin
                idx = idx - 3'(NUM_CH);
            end else begin
                idx = idx;
            end
            if (req[idx[1:0]]) begin
                pick = idx[1:0];
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [1:0] next_ptr(input logic [1:0] grant);
        if (grant == 2'(NUM_CH - 1)) begin
            return 2'd0;
        end else begin
            return grant + 2'd1;
        end
    endfunction
`endif

    // Confirm event fires only on the CONFIRM-1 -> CONFIRM step of each counter.
    always_comb begin
        w_cfm_set = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cfm_set[i] = i_sensor_in[i] && (r_cnt[i] == 4'(CONFIRM - 1));
        end
    end

    // Per-channel consecutive-high counters, saturating so a held sensor fires once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!i_sensor_in[i]) begin
                    r_cnt[i] <= 4'd0;
                end else if (r_cnt[i] != 4'(CONFIRM)) begin
                    r_cnt[i] <= r_cnt[i] + 4'd1;
                end
            end
        end
    end

    // Arbitration among the currently pending channels.
    always_comb begin
`ifdef ALARM_FIXED_PRIO_EN
        w_grant = prio_pick(r_pending);
`else
        w_grant = rr_pick(r_pending, r_ptr);
`endif
        w_grant_oh = {{(NUM_CH - 1){1'b0}}, 1'b1} << w_grant;
    end

    // Scheduler next-state: grant, sound for ALARM_LEN, silent gap, or abort on enable low.
    always_comb begin
        w_state_nxt     = r_state;
        w_dur_nxt       = r_dur;
        w_buzzer_nxt    = r_buzzer;
        w_active_id_nxt = r_active_id;
        w_ptr_nxt       = r_ptr;
        w_grant_clr     = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable && (r_pending != '0)) begin
                    w_state_nxt     = ST_SOUND;
                    w_dur_nxt       = 8'd1;
                    w_buzzer_nxt    = w_grant_oh;
                    w_active_id_nxt = w_grant;
                    w_ptr_nxt       = next_ptr(w_grant);
                    w_grant_clr     = w_grant_oh;
                end else begin
                    w_buzzer_nxt = '0;
                end
            end
            ST_SOUND: begin
                if (!i_enable) begin
                    w_state_nxt  = ST_IDLE;
                    w_dur_nxt    = 8'd0;
                    w_buzzer_nxt = '0;
                end else if (r_dur == 8'(ALARM_LEN)) begin
                    w_buzzer_nxt = '0;
                    if (GAP_LEN == 0) begin
                        w_state_nxt = ST_IDLE;
                        w_dur_nxt   = 8'd0;
                    end else begin
                        w_state_nxt = ST_GAP;
                        w_dur_nxt   = 8'd1;
                    end
                end else begin
                    w_dur_nxt = r_dur + 8'd1;
                end
            end
            ST_GAP: begin
                w_buzzer_nxt = '0;
                if (!i_enable || (r_dur == 8'(GAP_LEN))) begin
                    w_state_nxt = ST_IDLE;
                    w_dur_nxt   = 8'd0;
                end else begin
                    w_dur_nxt = r_dur + 8'd1;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_dur_nxt    = 8'd0;
                w_buzzer_nxt = '0;
            end
        endcase
    end

    // clear_all beats a same-edge confirm; a confirm beats a same-edge grant clear.
    always_comb begin
        if (i_clear_all) begin
            w_pending_nxt = '0;
        end else begin
            w_pending_nxt = (r_pending & ~w_grant_clr) | w_cfm_set;
        end
    end

    // Scheduler and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_dur       <= 8'd0;
            r_buzzer    <= '0;
            r_busy      <= 1'b0;
            r_pending   <= '0;
            r_active_id <= 2'd0;
            r_ptr       <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_dur       <= w_dur_nxt;
            r_buzzer    <= w_buzzer_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_pending   <= w_pending_nxt;
            r_active_id <= w_active_id_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

    assign o_buzzer_out = r_buzzer;
    assign o_busy       = r_busy;
    assign o_pending    = r_pending;
    assign o_active_id  = r_active_id;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Self-checking bench for alarm_scheduler: vector table, directed corner sequences, random vs model.
module tb_alarm_scheduler;

    localparam int NC        = 3;
    localparam int CONFIRM   = 7;
    localparam int ALARM_LEN = 31;
    localparam int GAP_LEN   = 4;

    logic          clk;
    logic          i_rst;
    logic          i_enable;
    logic [NC-1:0] i_sensor_in;
    logic          i_clear_all;
    logic [NC-1:0] o_buzzer_out;
    logic          o_busy;
    logic [NC-1:0] o_pending;
    logic [1:0]    o_active_id;

    int n_cmp;
    int n_err;

    alarm_scheduler #(
        .NUM_CH(NC), .CONFIRM(CONFIRM), .ALARM_LEN(ALARM_LEN), .GAP_LEN(GAP_LEN)
    ) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_enable(i_enable),
        .i_sensor_in(i_sensor_in),
        .i_clear_all(i_clear_all),
        .o_buzzer_out(o_buzzer_out),
        .o_busy(o_busy),
        .o_pending(o_pending),
        .o_active_id(o_active_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: run lengths, pending set, and a mode with a countdown of remaining cycles.
    int            m_run [NC];
    logic [NC-1:0] m_pend;
    int            m_mode;
    int            m_left;
    int            m_cur;
    int            m_ptr;

    task automatic model_reset();
        for (int i = 0; i < NC; i++) m_run[i] = 0;
        m_pend = '0;
        m_mode = 0;
        m_left = 0;
        m_cur  = 0;
        m_ptr  = 0;
    endtask

    task automatic model_step(input logic en, input logic [NC-1:0] s, input logic clr);
        logic [NC-1:0] evt;
        logic [NC-1:0] served;
        int            g;
        evt    = '0;
        served = '0;
        for (int i = 0; i < NC; i++) begin
            m_run[i] = s[i] ? m_run[i] + 1 : 0;
            if (m_run[i] == CONFIRM) evt[i] = 1'b1;
        end
        if (m_mode == 0) begin
            if (en && m_pend != '0) begin
                g = -1;
`ifdef ALARM_FIXED_PRIO_EN
                for (int c = 0; c < NC; c++) if (g < 0 && m_pend[c]) g = c;
`else
                for (int k = 0; k < NC; k++) if (g < 0 && m_pend[(m_ptr + k) % NC]) g = (m_ptr + k) % NC;
                m_ptr = (g + 1) % NC;
`endif
                m_mode    = 1;
                m_left    = ALARM_LEN;
                m_cur     = g;
                served[g] = 1'b1;
            end
        end else if (!en) begin
            m_mode = 0;
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (m_mode == 1 && GAP_LEN > 0) begin
                    m_mode = 2;
                    m_left = GAP_LEN;
                end else begin
                    m_mode = 0;
                end
            end
        end
        m_pend = clr ? '0 : ((m_pend & ~served) | evt);
    endtask

    function automatic logic [8:0] model_outs();
        logic [NC-1:0] b;
        b = (m_mode == 1) ? NC'(1 << m_cur) : '0;
        return {b, (m_mode != 0), m_pend, 2'(m_cur)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input logic en, input logic [NC-1:0] s, input logic clr);
        i_enable    = en;
        i_sensor_in = s;
        i_clear_all = clr;
        @(posedge clk);
        model_step(en, s, clr);
        #1;
        check("model", 32'({o_buzzer_out, o_busy, o_pending, o_active_id}), 32'(model_outs()));
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_enable = 1'b0; i_sensor_in = '0; i_clear_all = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b0;
        model_reset();
        check("reset_state", 32'({o_buzzer_out, o_busy, o_pending, o_active_id}), 32'd0);
    endtask

    typedef struct {
        logic          en;
        logic [NC-1:0] sens;
        logic          clr;
        logic [NC-1:0] buzz;
        logic          busy;
        logic [NC-1:0] pend;
        logic [1:0]    id;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int            hi;
        int            gap;
        int            seen;
        int            order;
        int            grants [$];
        logic [NC-1:0] prev_b;
        n_cmp = 0;
        n_err = 0;

        // Confirm and latency: ch0 high for seven edges, then buzzer one edge after pending.
        for (int k = 0; k < 7; k++) tbl[k] = '{1'b1, 3'b001, 1'b0, 3'b000, 1'b0, 3'b000, 2'd0};
        tbl[6].pend = 3'b001;
        for (int k = 7; k < 10; k++) tbl[k] = '{1'b1, 3'b000, 1'b0, 3'b001, 1'b1, 3'b000, 2'd0};

        do_reset();
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            tick(tbl[k].en, tbl[k].sens, tbl[k].clr);
            check($sformatf("vec%0d", k), 32'({o_buzzer_out, o_busy, o_pending, o_active_id}),
                  32'({tbl[k].buzz, tbl[k].busy, tbl[k].pend, tbl[k].id}));
            if (o_buzzer_out != '0) hi++;
        end
        for (int n = 0; n < 100 && o_buzzer_out != '0; n++) begin
            tick(1'b1, 3'b000, 1'b0);
            if (o_buzzer_out != '0) hi++;
        end
        check("alarm_len", 32'(hi), 32'(ALARM_LEN));
        gap = o_busy ? 1 : 0;
        for (int n = 0; n < 100 && o_busy; n++) begin
            tick(1'b1, 3'b000, 1'b0);
            if (o_busy) gap++;
        end
        check("gap_len", 32'(gap), 32'(GAP_LEN));
        check("idle_after_gap", 32'(o_busy), 32'd0);

        // Glitch reject: one low sample in the middle restarts the count.
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            tick(1'b1, (k == 6 || k >= 13) ? 3'b000 : 3'b010, 1'b0);
            if (o_pending != '0 || o_buzzer_out != '0) seen++;
        end
        check("glitch_reject", 32'(seen), 32'd0);

        // Round-robin from reset, then abort ch2 at its tenth sounding cycle.
        do_reset();
        for (int k = 0; k < 7; k++) tick(1'b1, 3'b111, 1'b0);
        check("rr_pend_all", 32'(o_pending), 32'b111);
        prev_b = '0;
        for (int n = 0; n < 300 && o_buzzer_out != 3'b100; n++) begin
            tick(1'b1, 3'b000, 1'b0);
            if (o_buzzer_out != '0 && prev_b == '0) grants.push_back(int'(o_active_id));
            prev_b = o_buzzer_out;
        end
        order = 0;
        foreach (grants[i]) order = order * 4 + grants[i];
        check("rr_count", 32'(grants.size()), 32'd3);
        check("rr_order", 32'(order), 32'd6);
        for (int k = 0; k < 9; k++) tick(1'b1, 3'b000, 1'b0);
        check("abort_pre_buzz", 32'(o_buzzer_out), 32'b100);
        tick(1'b0, 3'b000, 1'b0);
        check("abort_buzz", 32'(o_buzzer_out), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_pend2", 32'(o_pending[2]), 32'd0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 3'b000, 1'b0);
            if (o_busy) seen++;
        end
        check("reenable_idle", 32'(seen), 32'd0);

        // clear_all on the confirm edge wins, and nothing sounds afterwards.
        for (int k = 0; k < 6; k++) tick(1'b1, 3'b010, 1'b0);
        tick(1'b1, 3'b010, 1'b1);
        check("clear_collision", 32'(o_pending), 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1'b1, 3'b000, 1'b0);
            if (o_buzzer_out != '0) seen++;
        end
        check("clear_no_alarm", 32'(seen), 32'd0);

        // Asynchronous reset while ch2 sounds and ch0 is pending.
        for (int k = 0; k < 7; k++) tick(1'b1, 3'b100, 1'b0);
        for (int k = 0; k < 7; k++) tick(1'b1, 3'b001, 1'b0);
        check("pre_rst_state", 32'({o_buzzer_out, o_pending, o_active_id}), 32'({3'b100, 3'b001, 2'd2}));
        #2;
        i_rst = 1'b1;
        #1;
        check("async_rst_buzz", 32'(o_buzzer_out), 32'd0);
        check("async_rst_busy", 32'(o_busy), 32'd0);
        check("async_rst_pend", 32'(o_pending), 32'd0);
        check("async_rst_id", 32'(o_active_id), 32'd0);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        model_reset();
        for (int k = 0; k < 8; k++) tick(1'b1, (k < 7) ? 3'b010 : 3'b000, 1'b0);
        check("post_rst_grant", 32'({o_buzzer_out, o_active_id}), 32'({3'b010, 2'd1}));

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [NC-1:0] s;
            for (int i = 0; i < NC; i++) s[i] = ($urandom_range(0, 15) != 0);
            tick($urandom_range(0, 63) != 0, s, $urandom_range(0, 99) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
- Shares one audible alarm resource between NUM_CH sensor channels.
- Each channel's sensor is qualified by a consecutive-sample confirm counter before it raises a sticky pending request.
- A round-robin scheduler grants one channel at a time and drives its one-hot buzzer line for a fixed alarm length, then enforces a silent gap.
- Sits between the ui_in sensor pins and the uo_out buzzer pins of the tile.

Parameters:
- NUM_CH, 3, number of sensor/buzzer channels (legal 2..4).
- CONFIRM, 7, consecutive high samples needed to confirm a sensor event (legal 1..15).
- ALARM_LEN, 31, cycles the granted buzzer line stays high (legal 1..255).
- GAP_LEN, 4, silent cycles after each alarm before the next grant (legal 0..255).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  scheduler enable; confirm logic runs regardless.
- sensor_in  input  NUM_CH  raw sensor levels, synchronous to clk.
- clear_all  input  1  one-cycle pulse: drop all pending requests.
- buzzer_out  output  NUM_CH  one-hot (or zero) buzzer drive.
- busy  output  1  high in SOUND or GAP.
- pending  output  NUM_CH  sticky confirmed-but-unserved requests.
- active_id  output  2  index of the channel currently/last granted.

Behaviour:
- Reset (async, rst=1): buzzer_out=0, busy=0, pending=0, active_id=0, all confirm counters=0, round-robin pointer=0, state=IDLE, duration counter=0.
- Confirm, per channel i:
  - sensor_in[i]=0 clears cnt[i].
  - sensor_in[i]=1 increments cnt[i], saturating at CONFIRM.
  - pending[i] sets on the edge where cnt[i] goes CONFIRM-1 -> CONFIRM; sensor high at edges 1..CONFIRM gives pending visible after edge CONFIRM.
  - A continuously high sensor produces exactly one event. It must go low at least one cycle to re-arm.
- States are IDLE, SOUND and GAP.
- IDLE:
  - If enable=1 and pending!=0, grant the first pending channel at or after the pointer, wrapping modulo NUM_CH.
  - On the next edge: state=SOUND, buzzer_out=one-hot(grant), active_id=grant, pending[grant] cleared, pointer=grant+1 mod NUM_CH, dur=1.
  - Latency from pending visible to buzzer high is 1 cycle.
- SOUND:
  - buzzer_out held; dur increments each cycle.
  - When dur==ALARM_LEN: buzzer_out=0 next edge, state=GAP (dur=1), or IDLE if GAP_LEN==0.
  - Buzzer is high for exactly ALARM_LEN cycles.
- GAP:
  - buzzer_out=0, busy=1.
  - When dur==GAP_LEN, next edge goes to IDLE.
  - No grant occurs in the same edge as leaving GAP.
- enable=0 in SOUND or GAP: next edge goes to IDLE with buzzer_out=0, busy=0. The served channel is not re-pended. pending and confirm counters keep running.
- clear_all: next edge pending=0. It has priority over a simultaneous confirm set. It does not abort an alarm in progress.
- Same-channel confirm while that channel is sounding sets pending again; it is served after the current gap.
- Simultaneous confirms on several channels all set; they are served in round-robin order.
- A confirm set on the same edge as that channel's grant-clear: the set wins.
- dur width is 8 bits. active_id holds its value after the alarm ends.

Optional Feature:
- ALARM_FIXED_PRIO_EN defined: the grant is the lowest-index pending channel, the pointer is unused and held at 0, and all other behaviour is unchanged.
- ALARM_FIXED_PRIO_EN undefined: round-robin as above.

Test Plan:
- Confirm/latency: defaults, enable=1; sensor_in=3'b001 for 7 cycles.
  - pending=001 after 7th edge; next edge buzzer_out=001, active_id=0, pending=000.
  - buzzer high 31 cycles, then busy for 4 gap cycles, then busy=0.
- Glitch reject: sensor_in[1] high 6 cycles, low 1, high 6 -> pending stays 000 and buzzer_out stays 000 throughout.
- Round-robin: all three sensors high 7 cycles together -> pending=111; grants in order ch0, ch1, ch2, each 31 cycles on plus 4 gap. Under ALARM_FIXED_PRIO_EN, re-confirming ch0 during ch1's gap serves ch0 before ch2.
- Abort: deassert enable at cycle 10 of ch2's SOUND -> next edge buzzer_out=000, busy=0, pending[2]=0. Re-enable with no pending -> stays IDLE.
- Clear/collision: clear_all on the same edge ch1 confirms -> pending=000. No alarm follows.
- Reset mid-operation: assert rst during SOUND (async, between edges) -> buzzer_out, busy, pending and active_id go 0 immediately. After release, a fresh 7-cycle confirm on ch1 grants ch1 (pointer back at 0, so RR search starts at 0).
